clk_reset_seq: RTL

Stimulus and reset sequencer that drives the capture-register block: it generates the staggered active-low resets (`preset`, `qreset`) and the 32-bit sample word `ival` that the capture block slices into its registers. It releases the resets in a fixed order after a programmable hold, then steps `ival` through a maximal-length 32-bit LFSR sequence. It sits in the shared clock/reset test harness, one instance per capture block.

---
 rtl/clk_pkg.sv | 9 +
 rtl/clk_reset_seq_if.sv | 12 +
 rtl/clk_lfsr32.sv | 16 +
 rtl/clk_reset_seq.sv | 77 +++++++
 4 files changed

// File: rtl/clk_pkg.sv
// clk_pkg: shared types, constants and LFSR step function for the reset/stimulus sequencer.
package clk_pkg;
  localparam int CNT_W = 8;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  typedef enum logic [1:0] {HOLD, REL_P, REL_Q, RUN} state_t;
  function automatic logic [31:0] lfsr_next(input logic [31:0] word);
    return (word >> 1) ^ (word[0] ? LFSR_MASK : 32'h0);
  endfunction
endpackage

// File: rtl/clk_reset_seq_if.sv
// clk_reset_seq_if: control inputs and capture-block drive signals of the sequencer.
interface clk_reset_seq_if;
  logic enable;
  logic restart;
  logic preset;
  logic qreset;
  logic [31:0] ival;
  logic ival_valid;
  logic busy;
  modport master(input enable, restart, output preset, qreset, ival, ival_valid, busy);
  modport slave(output enable, restart, input preset, qreset, ival, ival_valid, busy);
endinterface

// File: rtl/clk_lfsr32.sv
// clk_lfsr32: 32-bit sample register with seed load, LFSR step and hold.
module clk_lfsr32
  import clk_pkg::*;
(
  input  logic        sysclk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);
  always_ff @(posedge sysclk or posedge reset)
    if (reset) q <= '0;
    else if (load) q <= seed;
    else if (step) q <= lfsr_next(q);
endmodule

// File: rtl/clk_reset_seq.sv
// clk_reset_seq: staggered active-low reset release followed by an LFSR sample stream.
module clk_reset_seq
  import clk_pkg::*;
#(
  parameter int          RST_CYCLES = 4,
  parameter int          STAGGER    = 2,
  parameter logic [31:0] SEED       = 32'h0000_0001
) (
  input logic sysclk,
  input logic reset,
  clk_reset_seq_if.master bus
);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  state_t state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic load, step;
  logic preset_q, qreset_q, valid_q, busy_q;
  logic [31:0] q;
  always_comb begin
    state_d = state;
    count_d = '0;
    load = 1'b0;
    step = 1'b0;
    case (state)
      HOLD: begin
        state_d = (count == RST_LAST) ? REL_P : HOLD;
        count_d = (count == RST_LAST) ? '0 : count + 1'b1;
      end
      REL_P: begin
        load = (count == STG_LAST);
        state_d = load ? REL_Q : REL_P;
        count_d = load ? '0 : count + 1'b1;
      end
      REL_Q: state_d = RUN;
      RUN: step = bus.enable;
      default: state_d = HOLD;
    endcase
    // restart overrides everything, including the seed load and LFSR step
    if (bus.restart) begin
      state_d = HOLD;
      count_d = '0;
      load = 1'b0;
      step = 1'b0;
    end
  end
  always_ff @(posedge sysclk or posedge reset)
    if (reset) begin
      state <= HOLD;
      count <= '0;
      preset_q <= 1'b0;
      qreset_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      state <= state_d;
      count <= count_d;
      preset_q <= (state_d != HOLD);
      qreset_q <= (state_d == REL_Q) || (state_d == RUN);
      valid_q <= (state_d == RUN);
      busy_q <= (state_d != RUN);
    end
  clk_lfsr32 u_lfsr (
    .sysclk(sysclk),
    .reset(reset),
    .load(load),
    .seed(SEED_EFF),
    .step(step),
    .q(q)
  );
  assign bus.preset = preset_q;
  assign bus.qreset = qreset_q;
  assign bus.ival = q;
  assign bus.ival_valid = valid_q;
  assign bus.busy = busy_q;
endmodule
